// File: rtl/bus_arbiter_4_pkg.sv
// Shared types and constants for the 4-requester round-robin bus arbiter.
package bus_arbiter_4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  typedef logic [1:0] req_idx_t;

  // One-hot request/grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_4_if.sv
// Handshake and shared-bus signals between the four requesters and the arbiter.
// master: requester side; slave: arbiter side.
interface bus_arbiter_4_if #(
  parameter int DW = 8
);
  import bus_arbiter_4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DW-1:0]      din_a;
  logic [DW-1:0]      din_b;
  logic [DW-1:0]      din_c;
  logic [DW-1:0]      din_d;
  logic [NUM_REQ-1:0] gnt;
  req_idx_t           sel;
  logic               bus_en_n;
  logic [DW-1:0]      bus_data;
  logic               bus_valid;
  logic               preempt;

  modport master (
    output req, din_a, din_b, din_c, din_d,
    input  gnt, sel, bus_en_n, bus_data, bus_valid, preempt
  );

  modport slave (
    input  req, din_a, din_b, din_c, din_d,
    output gnt, sel, bus_en_n, bus_data, bus_valid, preempt
  );

endinterface

// File: rtl/bus_arbiter_4_rr_pick.sv
// Combinational round-robin picker: searches ptr, ptr+1, ptr+2, ptr+3 (mod 4)
// and reports the first index whose request is high.
module rr_pick
  import bus_arbiter_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output req_idx_t           winner,
  output logic               any
);

  req_idx_t w_idx;

  // Walk the search order backwards so the lowest offset from ptr wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = req_idx_t'(ptr + req_idx_t'(i));
      if (req[w_idx]) begin
        winner = w_idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// Four-requester round-robin bus arbiter with registered one-hot grant and a
// shared 4:1 data mux. Ownership lasts until the owner drops req; on release
// the next requester is granted at the same edge.
// Optional macro BUS_ARBITER_4_TIMEOUT_EN adds a hold counter that forces a
// release after HOLD_MAX owned cycles when another requester is waiting.
module bus_arbiter_4
  import bus_arbiter_4_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_4_if.slave bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 2..255");
  end

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  req_idx_t           r_sel;
  logic               r_bus_en_n;
  req_idx_t           r_ptr;

  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  req_idx_t           w_sel_nxt;
  logic               w_bus_en_n_nxt;
  req_idx_t           w_ptr_nxt;
  logic               w_new_grant;

  logic               w_own_req;
  logic               w_others;
  logic               w_force;
  logic [NUM_REQ-1:0] w_pick_req;
  req_idx_t           w_pick_ptr;
  req_idx_t           w_winner;
  logic               w_any;
  logic               w_valid;
  logic [DW-1:0]      w_data;

  assign w_own_req = bus.req[r_sel];
  assign w_others  = |(bus.req & ~idx_to_onehot(r_sel));

  // While owning, the search starts just past the owner and skips it, which
  // covers both a voluntary release and a forced one.
  assign w_pick_req = (r_state == OWN) ? (bus.req & ~idx_to_onehot(r_sel)) : bus.req;
  assign w_pick_ptr = (r_state == OWN) ? req_idx_t'(r_sel + 2'd1) : r_ptr;

  rr_pick u_rr_pick (
    .req    (w_pick_req),
    .ptr    (w_pick_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

`ifdef BUS_ARBITER_4_TIMEOUT_EN
  localparam logic [7:0] HOLD_CAP = 8'(HOLD_MAX - 1);

  logic [7:0] r_hold;
  logic       r_preempt;

  assign w_force = (r_state == OWN) && (r_hold == HOLD_CAP) && w_own_req && w_others;

  // Hold counter: cleared on each new grant, counts owned cycles, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
    end else if (w_new_grant) begin
      r_hold <= '0;
    end else if (r_state == OWN && r_hold != HOLD_CAP) begin
      r_hold <= r_hold + 8'd1;
    end
  end

  // One-cycle pulse following a timeout-forced release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_force;
    end
  end

  assign bus.preempt = r_preempt;
`else
  assign w_force     = 1'b0;
  assign bus.preempt = 1'b0;
`endif

  // Next-state and next-output decode for the IDLE/OWN machine.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_sel_nxt      = r_sel;
    w_bus_en_n_nxt = r_bus_en_n;
    w_ptr_nxt      = r_ptr;
    w_new_grant    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt    = OWN;
          w_gnt_nxt      = idx_to_onehot(w_winner);
          w_sel_nxt      = w_winner;
          w_bus_en_n_nxt = 1'b0;
          w_new_grant    = 1'b1;
        end
      end
      OWN: begin
        if (!w_own_req || w_force) begin
          w_ptr_nxt = req_idx_t'(r_sel + 2'd1);
          if (w_any) begin
            w_gnt_nxt   = idx_to_onehot(w_winner);
            w_sel_nxt   = w_winner;
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt    = IDLE;
            w_gnt_nxt      = '0;
            w_bus_en_n_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_gnt_nxt      = '0;
        w_bus_en_n_nxt = 1'b1;
      end
    endcase
  end

  // State, grant, select and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_bus_en_n <= 1'b1;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_bus_en_n <= w_bus_en_n_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  assign w_valid = (r_state == OWN) && w_own_req;

  // Shared 4:1 data mux, forced to zero whenever the bus is not valid.
  always_comb begin
    w_data = '0;
    if (w_valid) begin
      case (r_sel)
        2'd0:    w_data = bus.din_a;
        2'd1:    w_data = bus.din_b;
        2'd2:    w_data = bus.din_c;
        default: w_data = bus.din_d;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.bus_en_n  = r_bus_en_n;
  assign bus.bus_valid = w_valid;
  assign bus.bus_data  = w_data;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed self-checking bench for bus_arbiter_4 (HOLD_MAX=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_arbiter_4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [7:0] exp_din [4];

  bus_arbiter_4_if #(.DW(8)) u_if ();

  bus_arbiter_4 #(.DW(8), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    u_if.req  = 4'b0000;
    tick();
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    int o;
    int cnt;
    int pre;
    n_checks = 0;
    n_errors = 0;
    exp_din[0] = 8'hA5;
    exp_din[1] = 8'h3C;
    exp_din[2] = 8'h5A;
    exp_din[3] = 8'hC3;
    reset      = 1'b1;
    u_if.req   = 4'b0000;
    u_if.din_a = exp_din[0];
    u_if.din_b = exp_din[1];
    u_if.din_c = exp_din[2];
    u_if.din_d = exp_din[3];
    tick();
    tick();

    // Reset state
    chk("rst_gnt", 32'(u_if.gnt), 32'h0);
    chk("rst_sel", 32'(u_if.sel), 32'h0);
    chk("rst_en_n", 32'(u_if.bus_en_n), 32'h1);
    chk("rst_valid", 32'(u_if.bus_valid), 32'h0);
    chk("rst_data", 32'(u_if.bus_data), 32'h0);
    chk("rst_preempt", 32'(u_if.preempt), 32'h0);

    // Single request right after reset
    reset    = 1'b0;
    u_if.req = 4'b0001;
    tick();
    chk("single_gnt", 32'(u_if.gnt), 32'h1);
    chk("single_data", 32'(u_if.bus_data), 32'hA5);
    chk("single_valid", 32'(u_if.bus_valid), 32'h1);
    chk("single_en_n", 32'(u_if.bus_en_n), 32'h0);
    u_if.req = 4'b0000;
    tick();
    chk("single_rel_gnt", 32'(u_if.gnt), 32'h0);
    chk("single_rel_en_n", 32'(u_if.bus_en_n), 32'h1);
    tick();
    tick();
    chk("idle_hold_gnt", 32'(u_if.gnt), 32'h0);
    chk("idle_hold_valid", 32'(u_if.bus_valid), 32'h0);

    // All four requesting, each owner drops after two cycles then re-raises
    do_reset();
    u_if.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      o = i % 4;
      chk("rr_gnt", 32'(u_if.gnt), 32'(1 << o));
      chk("rr_sel", 32'(u_if.sel), 32'(o));
      chk("rr_data", 32'(u_if.bus_data), 32'(exp_din[o]));
      chk("rr_valid", 32'(u_if.bus_valid), 32'h1);
      tick();
      chk("rr_gnt2", 32'(u_if.gnt), 32'(1 << o));
      chk("rr_data2", 32'(u_if.bus_data), 32'(exp_din[o]));
      if (i == 4) u_if.req = 4'b0000;
      else        u_if.req[o] = 1'b0;
      #1;
      chk("rr_rel_valid", 32'(u_if.bus_valid), 32'h0);
      chk("rr_rel_data", 32'(u_if.bus_data), 32'h0);
      tick();
      if (i < 4) u_if.req[o] = 1'b1;
    end
    chk("rr_end_gnt", 32'(u_if.gnt), 32'h0);
    chk("rr_end_en_n", 32'(u_if.bus_en_n), 32'h1);

    // Owner 2 releases with nobody waiting; pointer moves to 3
    do_reset();
    u_if.req = 4'b0100;
    tick();
    chk("own2_gnt", 32'(u_if.gnt), 32'h4);
    chk("own2_sel", 32'(u_if.sel), 32'h2);
    u_if.req = 4'b0000;
    tick();
    chk("own2_rel_gnt", 32'(u_if.gnt), 32'h0);
    chk("own2_rel_en_n", 32'(u_if.bus_en_n), 32'h1);
    chk("own2_rel_data", 32'(u_if.bus_data), 32'h0);
    u_if.req = 4'b1001;
    tick();
    chk("ptr3_gnt", 32'(u_if.gnt), 32'h8);
    chk("ptr3_data", 32'(u_if.bus_data), 32'hC3);

    // Reset in the middle of owner 3's burst
    tick();
    chk("mid_gnt", 32'(u_if.gnt), 32'h8);
    reset = 1'b1;
    tick();
    chk("midrst_gnt", 32'(u_if.gnt), 32'h0);
    chk("midrst_sel", 32'(u_if.sel), 32'h0);
    chk("midrst_en_n", 32'(u_if.bus_en_n), 32'h1);
    chk("midrst_valid", 32'(u_if.bus_valid), 32'h0);
    reset    = 1'b0;
    u_if.req = 4'b1111;
    tick();
    chk("postrst_gnt", 32'(u_if.gnt), 32'h1);

    // Owner 0 held while requester 1 waits
    do_reset();
    u_if.req = 4'b0011;
    tick();
    cnt = 0;
    pre = 0;
`ifdef BUS_ARBITER_4_TIMEOUT_EN
    for (int k = 0; k < 50; k++) begin
      if (u_if.preempt) pre++;
      if (u_if.gnt != 4'b0001) break;
      cnt++;
      tick();
    end
    chk("to_hold_cycles", 32'(cnt), 32'd4);
    chk("to_gnt_after", 32'(u_if.gnt), 32'h2);
    chk("to_preempt_seen", 32'(pre), 32'd1);
    tick();
    chk("to_preempt_clr", 32'(u_if.preempt), 32'h0);
    u_if.req = 4'b0010;
    for (int k = 0; k < 10; k++) tick();
    chk("to_sat_gnt", 32'(u_if.gnt), 32'h2);
    chk("to_sat_preempt", 32'(u_if.preempt), 32'h0);
`else
    for (int k = 0; k < 50; k++) begin
      if (u_if.preempt) pre++;
      if (u_if.gnt == 4'b0001) cnt++;
      tick();
    end
    chk("nto_hold_cycles", 32'(cnt), 32'd50);
    chk("nto_preempt_seen", 32'(pre), 32'd0);
    chk("nto_gnt_still", 32'(u_if.gnt), 32'h1);
`endif
    u_if.req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 Parameter DW, default 8: data width of every requester port and of the shared bus.
REQ-002 Parameter HOLD_MAX, default 8: maximum granted cycles per ownership; legal range 2..255. Used only under BUS_ARBITER_4_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 req  in  4  request per requester 0..3; held high for the whole burst.
REQ-006 din_a, din_b, din_c, din_d  in  DW each  requester 0..3 data.
REQ-007 gnt  out  4  one-hot grant, registered; all-zero when no owner.
REQ-008 sel  out  2  index of the current owner, registered; drives the shared 4:1 bus select.
REQ-009 bus_en_n  out  1  shared-mux enable, active-low, registered; 0 only while an owner exists.
REQ-010 bus_data  out  DW  equals the owner's din while bus_valid is 1, else all zeros.
REQ-011 bus_valid  out  1  combinational: (owner exists) AND req[sel].
REQ-012 preempt  out  1  one-cycle pulse on a timeout-forced release; tied 0 when the macro is absent.

Function
REQ-013 FSM states: IDLE (no owner, gnt=0, bus_en_n=1) and OWN (exactly one gnt bit set, bus_en_n=0).
REQ-014 Round-robin pointer ptr[1:0]: the search order is ptr, ptr+1, ptr+2, ptr+3 mod 4; the first index with req high wins.
REQ-015 IDLE with req != 0 at edge N: gnt/sel/bus_en_n take the winner at edge N, so first valid data appears in cycle N+1 (1-cycle latency).
REQ-016 IDLE with req == 0: remain IDLE, outputs unchanged.
REQ-017 OWN with req[sel] high: hold ownership; bus_valid=1 and bus_data=owner din in every such cycle.
REQ-018 OWN with req[sel] low at an edge (release): ptr <= sel+1 mod 4; the winner among the remaining requests is granted at the same edge with no idle gap; if none remain, go to IDLE.
REQ-019 Release cycle: bus_valid=0 and bus_data=0 in the cycle where req[sel] is already low.
REQ-020 Simultaneous requests: exactly one grant, chosen per REQ-014; losers wait with req held and receive no loss indication.
REQ-021 A requester that drops and immediately re-raises req is treated as a new request, and the round-robin order applies.
REQ-022 gnt is never multi-hot; sel always equals the index of the set gnt bit while in OWN.

Reset
REQ-023 reset high at an edge: state=IDLE, gnt=0, sel=0, bus_en_n=1, ptr=0, hold counter=0, preempt=0; this overrides any edge activity, including mid-burst.
REQ-024 The first arbitration after reset deasserts happens at the first edge with reset low; requester 0 has top priority.

Configuration
REQ-025 Macro BUS_ARBITER_4_TIMEOUT_EN defined: an 8-bit hold counter clears on each new grant and increments every OWN cycle.
REQ-026 Forced release: when hold counter == HOLD_MAX-1, req[sel] is high and another req bit is high, the next edge releases per REQ-018 and preempt=1 for one cycle.
REQ-027 At the limit with no other request, ownership continues; the counter saturates at HOLD_MAX-1 and preempt stays 0.
REQ-028 Macro absent: no counter is built, ownership lasts until req[sel] drops, and preempt is constant 0.

Structure
REQ-029 Shared package holds: the state enum (IDLE, OWN), the NUM_REQ=4 constant and the requester index typedef (2 bits).
REQ-030 One sub-module, rr_pick: combinational; inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any.

Verification
REQ-031 reset then req=4'b0001, din_a=8'hA5 -> gnt=0001 one cycle later, bus_data=A5, bus_valid=1, bus_en_n=0.
REQ-032 req=4'b1111 from IDLE with each owner dropping after 2 cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
REQ-033 Owner 2 is active and drops req while req=4'b0000 -> next edge gives gnt=0, bus_en_n=1, bus_data=0; ptr=3 is checked by a subsequent req=4'b1001 granting 3.
REQ-034 With the macro and HOLD_MAX=4: req[0] held and req[1] raised -> owner 0 gets exactly 4 cycles, preempt pulses once, then gnt=0010.
REQ-035 Without the macro, same stimulus -> owner 0 holds for 50 cycles with preempt=0.
REQ-036 reset asserted mid-burst with owner 3 active -> next edge gives gnt=0, sel=0, ptr=0, and req=4'b1111 then grants 0.
